mp_add_seq: RTL and testbench

MP_ADD_SEQ -- requirements
Module: mp_add_seq

---
 rtl/mp_add_seq.sv | 132 +++++++++++++
 tb/tb_mp_add_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision adder/subtractor: one byte per RUN cycle,
// results published together on the edge entering DONE.
module mp_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  ci,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   s,
  output logic                  co,
  output logic                  z,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           sub_q, sub_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   s_q, s_d;
  logic           co_q, co_d;
  logic           z_q, z_d;
  logic           ovf_q, ovf_d;

  logic [7:0]     a_byte  [NBYTES];
  logic [7:0]     bx_byte [NBYTES];
  logic [8:0]     sum;
  logic [W-1:0]   full_res;

  // Per-lane operand views; res_q collects bytes privately so s never shows partials.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign a_byte[gi]  = a_q[gi*8 +: 8];
    assign bx_byte[gi] = sub_q ? ~b_q[gi*8 +: 8] : b_q[gi*8 +: 8];
    assign res_d[gi*8 +: 8] = (state_q == S_RUN && idx_q == IW'(gi)) ? sum[7:0]
                                                                      : res_q[gi*8 +: 8];
  end

  assign sum      = {1'b0, a_byte[idx_q]} + {1'b0, bx_byte[idx_q]} + {8'd0, carry_q};
  assign full_res = {sum[7:0], res_q[W-9:0]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    s_d     = s_q;
    co_d    = co_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = ci ^ sub;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        carry_d = sum[8];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          s_d     = full_res;
          co_d    = sum[8] ^ sub_q;
          z_d     = (full_res == '0);
          ovf_d   = (a_q[W-1] == bx_byte[NBYTES-1][7]) && (full_res[W-1] != a_q[W-1]);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      z_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      s_q     <= s_d;
      co_q    <= co_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign z    = z_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq (NBYTES=4): arithmetic corner cases, latency,
// start handling, and reset abort.
module tb_mp_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         cp2;
  logic         ireset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         z;
  logic         ovf;

  int checks;
  int errors;
  logic [W-1:0] last_s;

  mp_add_seq #(.NBYTES(NBYTES)) dut (
    .cp2   (cp2),
    .ireset(ireset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .z     (z),
    .ovf   (ovf)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs during RUN, and check timing plus results.
  task automatic run_op(input string tag, input logic op_sub, input logic [W-1:0] op_a,
                        input logic [W-1:0] op_b, input logic op_ci,
                        input logic [W-1:0] exp_s, input logic exp_co,
                        input logic exp_z, input logic exp_ovf);
    int busy_cnt;
    int done_at;
    bit held;
    @(negedge cp2);
    start = 1'b1; sub = op_sub; a = op_a; b = op_b; ci = op_ci;
    @(posedge cp2);
    @(negedge cp2);
    start = 1'b0; sub = ~op_sub; a = ~op_a; b = op_b ^ 32'h5A5A_A5A5; ci = ~op_ci;
    busy_cnt = 0;
    done_at  = -1;
    held     = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_at = c;
        break;
      end
      if (s !== last_s) held = 1'b0;
      @(negedge cp2);
    end
    chk({tag, " latency"}, 64'(done_at), 64'(NBYTES));
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(NBYTES + 1));
    chk({tag, " s_held_in_run"}, 64'(held), 64'(1));
    chk({tag, " s"}, 64'(s), 64'(exp_s));
    chk({tag, " co"}, 64'(co), 64'(exp_co));
    chk({tag, " z"}, 64'(z), 64'(exp_z));
    chk({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
    @(negedge cp2);
    chk({tag, " done_pulse"}, 64'({busy, done}), 64'(0));
    chk({tag, " s_hold_after"}, 64'(s), 64'(exp_s));
    last_s = exp_s;
    $display("op %s sub=%0d a=%h b=%h ci=%0d -> s=%h co=%0d z=%0d ovf=%0d",
             tag, op_sub, op_a, op_b, op_ci, s, co, z, ovf);
  endtask

  logic [W-1:0] c5_exp [3];
  int           c5_done_k [3];
  int           c5_n;
  int           dn;

  initial begin
    checks = 0;
    errors = 0;
    last_s = '0;
    ireset = 1'b1;
    start  = 1'b1;
    sub    = 1'b0;
    a      = 32'h1234_5678;
    b      = 32'h1111_1111;
    ci     = 1'b0;

    // Reset with start also high: reset must win.
    repeat (3) @(posedge cp2);
    @(negedge cp2);
    chk("reset busy_done", 64'({busy, done}), 64'(0));
    chk("reset s", 64'(s), 64'(0));
    chk("reset flags", 64'({co, z, ovf}), 64'(0));
    start  = 1'b0;
    ireset = 1'b0;
    $display("reset released");

    // Case 1-4: arithmetic corners.
    run_op("c1_add_ff_1", 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("c2_add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("c2_add_ovf",  1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op("c3_sub_borrow", 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("c3_sub_ovf",  1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("c4_sub_bin1", 1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op("c4_sub_zero", 1'b1, 32'h0000_0004, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

    // Case 5: start held high with operands changing every cycle. Only cycles
    // k=0,6,12 are sampled in IDLE (5 busy cycles plus one IDLE cycle each).
    // k=0 : add 0x10000000+0x00+0        = 0x10000000
    // k=6 : sub 0x10000006-0x12-1        = 0x0FFFFFF3
    // k=12: sub 0x1000000C-0x24-0        = 0x0FFFFFE8
    c5_exp[0] = 32'h1000_0000;
    c5_exp[1] = 32'h0FFF_FFF3;
    c5_exp[2] = 32'h0FFF_FFE8;
    c5_n = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge cp2);
      if (done) begin
        if (c5_n < 3) begin
          c5_done_k[c5_n] = k;
          chk($sformatf("c5_s_%0d", c5_n), 64'(s), 64'(c5_exp[c5_n]));
          chk($sformatf("c5_co_%0d", c5_n), 64'(co), 64'(0));
          $display("c5 done at k=%0d s=%h", k, s);
        end
        c5_n++;
      end
      start = 1'b1;
      a     = 32'h1000_0000 + W'(k);
      b     = W'(k * 3);
      sub   = k[2];
      ci    = k[1];
    end
    @(negedge cp2);
    start = 1'b0;
    chk("c5_done_count", 64'(c5_n), 64'(3));
    if (c5_n == 3) begin
      chk("c5_first_done_k", 64'(c5_done_k[0]), 64'(5));
      chk("c5_interval_01", 64'(c5_done_k[1] - c5_done_k[0]), 64'(NBYTES + 2));
      chk("c5_interval_12", 64'(c5_done_k[2] - c5_done_k[1]), 64'(NBYTES + 2));
    end
    repeat (2) @(negedge cp2);
    chk("c5_idle_after", 64'(busy), 64'(0));
    last_s = c5_exp[2];

    // Case 6: reset during the second RUN cycle aborts with no done.
    @(negedge cp2);
    start = 1'b1; sub = 1'b0; a = 32'h0000_0001; b = 32'h0000_0001; ci = 1'b0;
    @(posedge cp2);
    @(negedge cp2);
    start = 1'b0;
    chk("c6_busy_run", 64'(busy), 64'(1));
    @(negedge cp2);
    ireset = 1'b1;
    @(posedge cp2);
    @(negedge cp2);
    chk("c6_abort_busy_done", 64'({busy, done}), 64'(0));
    chk("c6_abort_s", 64'(s), 64'(0));
    chk("c6_abort_flags", 64'({co, z, ovf}), 64'(0));
    ireset = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge cp2);
      if (done || busy) dn++;
    end
    chk("c6_no_done_after_abort", 64'(dn), 64'(0));
    $display("c6 abort checked");
    last_s = '0;
    run_op("c6_add_1_1", 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
